// File: rtl/toy_pack.sv
// Shared types for the toy core's M-extension unit: funct3 opcode decode,
// MDU state encoding, divider iteration count and a magnitude helper.
package toy_pack;

  localparam int MDU_XLEN     = 32;
  localparam int MDU_DIV_ITER = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } funct3_mul_t;

  typedef enum logic [2:0] {
    MDU_IDLE = 3'd0,
    MDU_MUL  = 3'd1,
    MDU_DIV  = 3'd2,
    MDU_FIX  = 3'd3,
    MDU_DONE = 3'd4
  } mdu_state_t;

  // Magnitude of v when treated as signed (sgn=1), else v unchanged.
  // abs(32'h8000_0000) wraps to itself, which is the correct unsigned magnitude.
  function automatic logic [MDU_XLEN-1:0] mdu_abs(input logic [MDU_XLEN-1:0] v, input logic sgn);
    return (sgn && v[MDU_XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/toy_mdu_divider.sv
// Unsigned restoring divider core: one quotient bit per cycle, ITER cycles.
// Loaded by start, cleared by flush; done is high during the final step.
module toy_mdu_divider
  import toy_pack::*;
#(
  parameter int ITER = MDU_DIV_ITER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  localparam logic [4:0] LAST_STEP = 5'(ITER - 1);

  logic [31:0] quo_reg;
  logic [31:0] rem_reg;
  logic [31:0] dvs_reg;
  logic [4:0]  cnt_reg;
  logic        active_reg;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;

  // Partial remainder shifted left with the next dividend bit; bit 32 of the
  // difference is the borrow, so a clear bit means the divisor fits.
  assign shifted   = {rem_reg, quo_reg[31]};
  assign diff      = shifted - {1'b0, dvs_reg};
  assign fits      = ~diff[32];
  assign done      = active_reg && (cnt_reg == LAST_STEP);
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

  // Iteration state: load on start, step while active, stop after last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_reg    <= '0;
      rem_reg    <= '0;
      dvs_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (flush) begin
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      quo_reg    <= dividend;
      rem_reg    <= '0;
      dvs_reg    <= divisor;
      cnt_reg    <= '0;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      quo_reg <= {quo_reg[30:0], fits};
      rem_reg <= fits ? diff[31:0] : shifted[31:0];
      cnt_reg <= cnt_reg + 5'd1;
      if (done) active_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/toy_mdu.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Multiplies take 2 cycles, divides 34 cycles, divide special cases 1 cycle.
// Optional build macro TOY_MDU_DIV_EARLY_EN: divides with |dividend| < |divisor|
// finish in 1 cycle instead of running the full divider.
module toy_mdu
  import toy_pack::*;
#(
  parameter int XLEN     = 32,
  parameter int DIV_ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [XLEN-1:0] req_rs2_val,
  input  logic [4:0]      req_rd_idx,
  output logic            resp_vld,
  input  logic            resp_rdy,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd_idx,
  output logic            busy
);

  mdu_state_t  state_reg;
  funct3_mul_t f3_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;

  // Request-side decode (combinational, used only when accepting)
  funct3_mul_t req_op;
  logic        accept;
  logic        req_is_div;
  logic        req_signed;
  logic        req_is_rem;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        div_zero;
  logic        div_ovf;
  logic        div_early;
  logic        div_special;
  logic [31:0] special_val;

  assign req_op     = funct3_mul_t'(req_funct3);
  assign req_rdy    = (state_reg == MDU_IDLE) && !flush;
  assign accept     = req_vld && req_rdy;
  assign req_is_div = req_funct3[2];
  assign req_signed = (req_op == F3_DIV) || (req_op == F3_REM);
  assign req_is_rem = req_funct3[1];
  assign mag_a      = mdu_abs(req_rs1_val, req_signed);
  assign mag_b      = mdu_abs(req_rs2_val, req_signed);
  assign div_zero   = (req_rs2_val == 32'd0);
  assign div_ovf    = req_signed && (req_rs1_val == 32'h8000_0000) && (req_rs2_val == 32'hFFFF_FFFF);

`ifdef TOY_MDU_DIV_EARLY_EN
  assign div_early  = !div_zero && (mag_a < mag_b);
`else
  assign div_early  = 1'b0;
`endif

  assign div_special = div_zero || div_ovf || div_early;

  // Result for divides resolved without iterating
  always_comb begin
    special_val = 32'd0;
    if (div_zero)     special_val = req_is_rem ? req_rs1_val : 32'hFFFF_FFFF;
    else if (div_ovf) special_val = req_is_rem ? 32'd0 : 32'h8000_0000;
    else              special_val = req_is_rem ? req_rs1_val : 32'd0;
  end

  // Multiplier: 33x33 signed product of the extended operands
  logic        a_sx;
  logic        b_sx;
  logic [63:0] prod;
  logic [31:0] mul_res;

  assign a_sx    = ((f3_reg == F3_MULH) || (f3_reg == F3_MULHSU)) && a_reg[31];
  assign b_sx    = (f3_reg == F3_MULH) && b_reg[31];
  assign prod    = 64'($signed({a_sx, a_reg}) * $signed({b_sx, b_reg}));
  assign mul_res = (f3_reg == F3_MUL) ? prod[31:0] : prod[63:32];

  // Divider and sign fix-up of its magnitude results
  logic        div_start;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        div_done;
  logic        fix_signed;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] fix_res;

  assign div_start  = accept && req_is_div && !div_special;
  assign fix_signed = (f3_reg == F3_DIV) || (f3_reg == F3_REM);
  assign neg_q      = fix_signed && (a_reg[31] ^ b_reg[31]);
  assign neg_r      = fix_signed && a_reg[31];
  assign fix_res    = f3_reg[1] ? (neg_r ? (~div_rem + 32'd1) : div_rem)
                                : (neg_q ? (~div_quo + 32'd1) : div_quo);

  toy_mdu_divider #(.ITER(DIV_ITER)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  assign resp_vld = (state_reg == MDU_DONE);
  assign busy     = (state_reg != MDU_IDLE);

  // Control FSM plus operand/result registers; flush beats both handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= MDU_IDLE;
      f3_reg      <= F3_MUL;
      a_reg       <= '0;
      b_reg       <= '0;
      resp_data   <= '0;
      resp_rd_idx <= '0;
    end else if (flush) begin
      state_reg <= MDU_IDLE;
    end else begin
      case (state_reg)
        MDU_IDLE: begin
          if (accept) begin
            f3_reg      <= req_op;
            a_reg       <= req_rs1_val;
            b_reg       <= req_rs2_val;
            resp_rd_idx <= req_rd_idx;
            if (!req_is_div) begin
              state_reg <= MDU_MUL;
            end else if (div_special) begin
              resp_data <= special_val;
              state_reg <= MDU_DONE;
            end else begin
              state_reg <= MDU_DIV;
            end
          end
        end
        MDU_MUL: begin
          resp_data <= mul_res;
          state_reg <= MDU_DONE;
        end
        MDU_DIV: begin
          if (div_done) state_reg <= MDU_FIX;
        end
        MDU_FIX: begin
          resp_data <= fix_res;
          state_reg <= MDU_DONE;
        end
        MDU_DONE: begin
          if (resp_rdy) state_reg <= MDU_IDLE;
        end
        default: state_reg <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: doc/toy_mdu.md
Name: toy_mdu

Overview:
- Iterative RV32M multiply/divide unit, downstream of the decoder in the execute stage.
- Accepts one decoded M-extension op (funct3_mul_t plus rs1/rs2 values and rd index) over a valid/ready handshake.
- Computes MUL/MULH/MULHSU/MULHU in 2 cycles and DIV/DIVU/REM/REMU by a 32-step restoring divider.
- Returns the result with rd index to writeback over a valid/ready handshake.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- DIV_ITER, 32, divider iterations; must equal XLEN.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill in-flight op (pipeline redirect/trap)
- req_vld  in  1  op valid
- req_rdy  out  1  unit can accept op
- req_funct3  in  3  funct3_mul_t opcode
- req_rs1_val  in  32  operand A
- req_rs2_val  in  32  operand B
- req_rd_idx  in  5  destination register index
- resp_vld  out  1  result valid
- resp_rdy  in  1  writeback accepts result
- resp_data  out  32  result
- resp_rd_idx  out  5  destination index of result
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low. On reset: state=IDLE, resp_vld=0, resp_data=0, resp_rd_idx=0, busy=0, all internal registers 0.
- req_rdy = (state==IDLE) & !flush. An op is accepted at edge T when req_vld & req_rdy. Operands, funct3 and rd are captured.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE -> MUL: for MUL* ops.
- IDLE -> DONE: for a DIV-class op when it is a special case or an early-out (see below).
- IDLE -> DIV: for all other DIV-class ops.
- MUL: computes a 33x33 signed product. Operands are sign- or zero-extended per op: MULH s*s, MULHSU s*u, MULHU u*u. The product is registered, then -> DONE. MUL returns product[31:0]; the others return product[63:32]. resp_vld is first high in cycle T+2.
- DIV: operates on magnitudes; signed ops take abs(). Quotient/remainder are computed one bit per cycle for 32 cycles, then -> FIX.
- FIX: negates the quotient if the operand signs differ (signed ops only). Negates the remainder if the dividend was negative. Then -> DONE. resp_vld is first high at T+34.
- Special cases, resolved in IDLE; result ready at T+1:
  - Divisor 0: DIV/DIVU return 32'hFFFF_FFFF; REM/REMU return the dividend.
  - DIV with 32'h8000_0000 / 32'hFFFF_FFFF: returns 32'h8000_0000; REM returns 0.
- DONE: resp_vld=1. resp_data and resp_rd_idx are held stable until resp_rdy. Handshake at an edge -> IDLE. A new request can be accepted no earlier than the cycle after the response handshake.
- flush: from any state, the next state is IDLE and resp_vld drops next cycle. This includes DONE with a pending resp_rdy. flush has priority over both handshakes. A flush coinciding with a req_vld accepts nothing.
- Reset mid-operation: the async clear returns the unit to IDLE immediately. No result is emitted.
- Arithmetic is modulo 2^32. funct3 values outside funct3_mul_t do not exist (3-bit field fully covered).

Optional Feature:
- Macro: TOY_MDU_DIV_EARLY_EN.
- Defined: in IDLE, if |dividend| < |divisor| (divisor != 0), go directly to DONE at T+1. Quotient = 0. Remainder = dividend, with its sign preserved as per RISC-V.
- Undefined: such ops take the full 34-cycle path. Results are identical in both builds; only latency differs.

Decomposition:
- toy_pack: add mdu_state_t enum {MDU_IDLE, MDU_MUL, MDU_DIV, MDU_FIX, MDU_DONE}.
- toy_pack: add MDU_DIV_ITER=32.
- Reuse the existing funct3_mul_t for opcode decode.
- Sub-module: toy_mdu_divider, the unsigned restoring core.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, done. done is asserted on the 32nd step.
  - It carries its own 5-bit iteration counter and is cleared by flush.
- toy_mdu owns the handshake, sign handling, special cases, and the multiplier.

Test Plan:
- MULH 32'h8000_0000 * 32'h8000_0000 -> resp_data 32'h4000_0000 at T+2. MULHU 32'hFFFF_FFFF * 32'hFFFF_FFFF -> 32'hFFFF_FFFE. MULHSU 32'hFFFF_FFFF * 32'h0000_0002 -> 32'hFFFF_FFFF.
- DIV -7 / 2 -> 32'hFFFF_FFFD (-3); REM -7 / 2 -> 32'hFFFF_FFFF (-1). Both with resp_vld at T+34 without TOY_MDU_DIV_EARLY_EN.
- DIVU 100/0 -> 32'hFFFF_FFFF at T+1; REMU 100/0 -> 100. DIV 32'h8000_0000 / -1 -> 32'h8000_0000; REM -> 0.
- Backpressure: DIVU 1000/7 with resp_rdy=0 for 10 cycles -> resp_vld held, data 142 and rd_idx stable, req_rdy=0. Release -> IDLE, next op accepted the following cycle.
- flush at iteration 15 of a DIV -> IDLE next cycle, no resp_vld, busy=0. A subsequent MUL 6*7 returns 42 at T+2.
- With TOY_MDU_DIV_EARLY_EN: REM 3/10 -> 3 and DIVU 3/10 -> 0, both at T+1. With the macro undefined, the same results at T+34.
